// File: rtl/pipe_stage_latch_if.sv
// rtl/pipe_stage_latch_if.sv - payload/control bundle between a pipeline stage and its latch
interface pipe_stage_latch_if #(
  parameter int NB_DATA = 71,
  parameter int NB_CNT  = 16
);
  localparam int NB_DBG = NB_DATA + NB_CNT + 4;

  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               i_stall;
  logic               i_flush;
  logic               i_EOF_flag;
  logic [1:0]         i_pipeline_mode;
  logic               i_execute_instruct;

  logic [NB_DATA-1:0] o_data;
  logic               o_valid;
  logic               o_EOF_flag;
  logic               o_halted;
  logic               o_advance;
  logic [NB_CNT-1:0]  o_count;
  logic [NB_DBG-1:0]  o_debug_data;

  modport master (
    output i_data, i_valid, i_stall, i_flush, i_EOF_flag, i_pipeline_mode, i_execute_instruct,
    input  o_data, o_valid, o_EOF_flag, o_halted, o_advance, o_count, o_debug_data
  );

  modport slave (
    input  i_data, i_valid, i_stall, i_flush, i_EOF_flag, i_pipeline_mode, i_execute_instruct,
    output o_data, o_valid, o_EOF_flag, o_halted, o_advance, o_count, o_debug_data
  );
endinterface

// File: rtl/pipe_stage_latch.sv
// rtl/pipe_stage_latch.sv - inter-stage pipeline register with stall/flush/step/halt and retire counter
// Optional debug snapshot built when PIPE_STAGE_LATCH_DEBUG_EN is defined.
module pipe_stage_latch #(
  parameter int NB_DATA = 71,
  parameter int NB_CNT  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pipe_stage_latch_if.slave    bus
);
  localparam int NB_DBG = NB_DATA + NB_CNT + 4;

  localparam logic [1:0] MODE_CONT = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b11;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    STEP_WAIT = 2'b01,
    HALT      = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic               exec_prev_q;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               eof_q, eof_d;
  logic [NB_CNT-1:0]  count_q, count_d;
  logic               advance_q, advance_d;

  logic step_pulse;
  logic update_en;
  logic capture;

  assign step_pulse = bus.i_execute_instruct & ~exec_prev_q;
  assign update_en  = (state_q != HALT) &&
                      ((bus.i_pipeline_mode == MODE_CONT) ||
                       ((bus.i_pipeline_mode == MODE_STEP) && step_pulse));
  assign capture    = update_en && !bus.i_flush && !bus.i_stall;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    eof_d     = eof_q;
    count_d   = count_q;
    advance_d = 1'b0;

    if (state_q != HALT) begin
      if (bus.i_pipeline_mode == MODE_CONT) begin
        state_d = RUN;
      end else if (bus.i_pipeline_mode == MODE_STEP) begin
        state_d = STEP_WAIT;
      end
    end

    // Flush wins over stall; a step swallowed by stall is simply lost.
    if (update_en && bus.i_flush) begin
      data_d    = '0;
      valid_d   = 1'b0;
      eof_d     = 1'b0;
      advance_d = 1'b1;
    end else if (capture) begin
      data_d    = bus.i_data;
      valid_d   = bus.i_valid;
      eof_d     = bus.i_EOF_flag;
      advance_d = 1'b1;
      if (bus.i_valid) begin
        if (count_q != {NB_CNT{1'b1}}) begin
          count_d = count_q + NB_CNT'(1);
        end
        if (bus.i_EOF_flag) begin
          state_d = HALT;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= RUN;
      exec_prev_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      eof_q       <= 1'b0;
      count_q     <= '0;
      advance_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      exec_prev_q <= bus.i_execute_instruct;
      data_q      <= data_d;
      valid_q     <= valid_d;
      eof_q       <= eof_d;
      count_q     <= count_d;
      advance_q   <= advance_d;
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_EOF_flag = eof_q;
  assign bus.o_halted   = (state_q == HALT);
  assign bus.o_advance  = advance_q;
  assign bus.o_count    = count_q;

`ifdef PIPE_STAGE_LATCH_DEBUG_EN
  assign bus.o_debug_data = {count_q, state_q, eof_q, valid_q, data_q};
`else
  assign bus.o_debug_data = {NB_DBG{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb/tb_pipe_stage_latch.sv - directed self-checking bench for pipe_stage_latch
module tb_pipe_stage_latch;
  localparam int NB_DATA = 8;
  localparam int NB_CNT  = 4;
  localparam int NB_DBG  = NB_DATA + NB_CNT + 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  pipe_stage_latch_if #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) bus ();

  pipe_stage_latch #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.i_data = 8'h77; bus.i_valid = 1'b1; bus.i_stall = 1'b0; bus.i_flush = 1'b0;
    bus.i_EOF_flag = 1'b0; bus.i_pipeline_mode = 2'b00; bus.i_execute_instruct = 1'b0;
    do_reset();
    tests++; if (bus.o_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %0h expected 0", bus.o_data); end
    tests++; if ({bus.o_valid, bus.o_EOF_flag, bus.o_halted, bus.o_advance} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b expected 0000", {bus.o_valid, bus.o_EOF_flag, bus.o_halted, bus.o_advance}); end
    tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus.o_count); end
    tests++; if (bus.o_debug_data !== {NB_DBG{1'b0}}) begin fails++; $display("FAIL reset_debug: got %0h expected 0", bus.o_debug_data); end
  endtask

  task automatic test_continuous();
    bus.i_pipeline_mode = 2'b01; bus.i_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.i_data = 8'(i);
      tick();
      tests++; if (bus.o_data !== 8'(i)) begin fails++; $display("FAIL cont_data%0d: got %0h expected %0h", i, bus.o_data, i); end
      tests++; if (bus.o_advance !== 1'b1) begin fails++; $display("FAIL cont_adv%0d: got %b expected 1", i, bus.o_advance); end
    end
    tests++; if (bus.o_count !== 4'd3) begin fails++; $display("FAIL cont_count: got %0d expected 3", bus.o_count); end
    bus.i_stall = 1'b1; bus.i_data = 8'h44;
    tick();
    tests++; if (bus.o_advance !== 1'b0) begin fails++; $display("FAIL cont_adv_drop: got %b expected 0", bus.o_advance); end
    tests++; if (bus.o_data !== 8'h03) begin fails++; $display("FAIL cont_hold: got %0h expected 3", bus.o_data); end
    bus.i_stall = 1'b0;
  endtask

  task automatic test_stall_flush();
    bus.i_data = 8'h05; bus.i_valid = 1'b1;
    tick();
    tests++; if (bus.o_data !== 8'h05 || bus.o_count !== 4'd4) begin
      fails++; $display("FAIL sf_load: got data %0h count %0d expected 5/4", bus.o_data, bus.o_count); end
    bus.i_stall = 1'b1; bus.i_data = 8'h06;
    tick();
    tests++; if (bus.o_data !== 8'h05 || bus.o_advance !== 1'b0 || bus.o_count !== 4'd4) begin
      fails++; $display("FAIL sf_stall: got data %0h adv %b count %0d expected 5/0/4", bus.o_data, bus.o_advance, bus.o_count); end
    bus.i_flush = 1'b1;
    tick();
    tests++; if (bus.o_data !== 8'h00 || bus.o_valid !== 1'b0) begin
      fails++; $display("FAIL sf_flush: got data %0h valid %b expected 0/0", bus.o_data, bus.o_valid); end
    tests++; if (bus.o_count !== 4'd4 || bus.o_advance !== 1'b1) begin
      fails++; $display("FAIL sf_flush_cnt: got count %0d adv %b expected 4/1", bus.o_count, bus.o_advance); end
    bus.i_flush = 1'b0; bus.i_stall = 1'b0;
  endtask

  task automatic test_stepwise();
    int adv_seen;
    bus.i_pipeline_mode = 2'b11; bus.i_execute_instruct = 1'b0; bus.i_data = 8'h0A; bus.i_valid = 1'b1;
    tick();
    tests++; if (bus.o_data !== 8'h00 || bus.o_advance !== 1'b0) begin
      fails++; $display("FAIL step_idle: got data %0h adv %b expected 0/0", bus.o_data, bus.o_advance); end
    bus.i_execute_instruct = 1'b1;
    adv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      adv_seen += int'(bus.o_advance);
    end
    tests++; if (adv_seen != 1) begin fails++; $display("FAIL step_single: got %0d advances expected 1", adv_seen); end
    tests++; if (bus.o_data !== 8'h0A || bus.o_count !== 4'd5) begin
      fails++; $display("FAIL step_capture: got data %0h count %0d expected A/5", bus.o_data, bus.o_count); end
    bus.i_execute_instruct = 1'b0;
    tick();
    bus.i_data = 8'h0B; bus.i_execute_instruct = 1'b1;
    tick();
    tests++; if (bus.o_data !== 8'h0B || bus.o_count !== 4'd6) begin
      fails++; $display("FAIL step_second: got data %0h count %0d expected B/6", bus.o_data, bus.o_count); end
    bus.i_execute_instruct = 1'b0;
    bus.i_pipeline_mode = 2'b10; bus.i_data = 8'h3C;
    tick(); tick();
    tests++; if (bus.o_data !== 8'h0B || bus.o_count !== 4'd6) begin
      fails++; $display("FAIL mode_freeze: got data %0h count %0d expected B/6", bus.o_data, bus.o_count); end
  endtask

  task automatic test_debug();
    logic [NB_DBG-1:0] exp_dbg;
    do_reset();
    bus.i_pipeline_mode = 2'b01; bus.i_data = 8'hAB; bus.i_valid = 1'b1; bus.i_EOF_flag = 1'b0;
    tick();
`ifdef PIPE_STAGE_LATCH_DEBUG_EN
    exp_dbg = 16'h11AB;
`else
    exp_dbg = 16'h0000;
`endif
    tests++; if (bus.o_debug_data !== exp_dbg) begin fails++; $display("FAIL debug_snap: got %0h expected %0h", bus.o_debug_data, exp_dbg); end
  endtask

  task automatic test_eof_halt();
    bus.i_pipeline_mode = 2'b01; bus.i_data = 8'h0C; bus.i_valid = 1'b1; bus.i_EOF_flag = 1'b1;
    tick();
    tests++; if (bus.o_EOF_flag !== 1'b1 || bus.o_halted !== 1'b1) begin
      fails++; $display("FAIL eof_edge: got eof %b halted %b expected 1/1", bus.o_EOF_flag, bus.o_halted); end
    tests++; if (bus.o_count !== 4'd2) begin fails++; $display("FAIL eof_count: got %0d expected 2", bus.o_count); end
    bus.i_EOF_flag = 1'b0; bus.i_data = 8'h0D;
    tick();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0; bus.i_pipeline_mode = 2'b11; bus.i_execute_instruct = 1'b1;
    tick();
    tests++; if (bus.o_data !== 8'h0C || bus.o_count !== 4'd2 || bus.o_advance !== 1'b0) begin
      fails++; $display("FAIL halt_frozen: got data %0h count %0d adv %b expected C/2/0", bus.o_data, bus.o_count, bus.o_advance); end
    tests++; if (bus.o_halted !== 1'b1 || bus.o_valid !== 1'b1) begin
      fails++; $display("FAIL halt_sticky: got halted %b valid %b expected 1/1", bus.o_halted, bus.o_valid); end
    bus.i_execute_instruct = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (bus.o_halted !== 1'b0 || bus.o_data !== 8'h00 || bus.o_count !== 4'd0 || bus.o_EOF_flag !== 1'b0) begin
      fails++; $display("FAIL async_reset: got halted %b data %0h count %0d eof %b expected 0/0/0/0",
                        bus.o_halted, bus.o_data, bus.o_count, bus.o_EOF_flag); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    bus.i_pipeline_mode = 2'b01; bus.i_valid = 1'b1; bus.i_EOF_flag = 1'b0;
    for (int i = 0; i < 15; i++) begin
      bus.i_data = 8'(i);
      tick();
    end
    tests++; if (bus.o_count !== 4'd15) begin fails++; $display("FAIL sat_reach: got %0d expected 15", bus.o_count); end
    bus.i_data = 8'h0F; tick();
    bus.i_data = 8'h10; tick();
    tests++; if (bus.o_count !== 4'd15) begin fails++; $display("FAIL sat_hold: got %0d expected 15", bus.o_count); end
    tests++; if (bus.o_data !== 8'h10) begin fails++; $display("FAIL sat_data: got %0h expected 10", bus.o_data); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_continuous();
    test_stall_flush();
    test_stepwise();
    test_debug();
    test_eof_halt();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
